// File: rtl/booth_mul_if.sv
// Operand-issue and result handshake bundle for booth_mul_pipe.
// The master issues operands and consumes results; the slave is the multiplier.
interface booth_mul_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_res;
  logic [2*WIDTH-1:0] out_prod;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_prod, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_prod, out_tag
  );
endinterface

// File: rtl/booth_mul_pipe.sv
// Radix-4 Booth / Wallace multiplier for MUL/MULH/MULHSU/MULHU; latency STAGES cycles, 1 op/cycle.
// Backpressure: valid/ready per stage, empty stages keep filling behind a stalled output.
module booth_mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  booth_mul_if.slave io
);
  localparam int NPP = WIDTH/2 + 1;
  localparam int PW  = 2*WIDTH;
  localparam int EW  = WIDTH + 2;

  logic [STAGES-1:0] v_q, v_d, adv;
  logic [1:0]        op_q  [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic              in_fire;

  // Operands widened by two bits so a single signed Booth array covers every mode.
  logic              a_sgn, b_sgn;
  logic [EW-1:0]     a_ext;
  logic [EW:0]       b_ext;
  logic [PW-1:0]     a_pw;
  logic [PW-1:0]     pp_d    [NPP];
  logic [PW-1:0]     tree_in [NPP];

  assign a_sgn = (io.in_op != 2'd3);
  assign b_sgn = (io.in_op[1] == 1'b0);
  assign a_ext = {{2{a_sgn & io.in_a[WIDTH-1]}}, io.in_a};
  assign b_ext = {{2{b_sgn & io.in_b[WIDTH-1]}}, io.in_b, 1'b0};
  assign a_pw  = {{(PW-EW){a_ext[EW-1]}}, a_ext};

  for (genvar j = 0; j < NPP; j++) begin : g_pp
    logic [2:0]    grp;
    logic [PW-1:0] mag;
    logic          neg;
    assign grp = b_ext[2*j+2 -: 3];
    always_comb begin
      mag = '0;
      neg = 1'b0;
      case (grp)
        3'b001, 3'b010: mag = a_pw;
        3'b011:         mag = a_pw << 1;
        3'b100:         begin mag = a_pw << 1; neg = 1'b1; end
        3'b101, 3'b110: begin mag = a_pw;      neg = 1'b1; end
        default:        mag = '0;
      endcase
    end
    assign pp_d[j] = ((mag ^ {PW{neg}}) + PW'(neg)) << (2*j);
  end

  if (STAGES == 3) begin : g_pp_reg
    logic [PW-1:0] pp_q [NPP];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NPP; i++) pp_q[i] <= '0;
      end else if (adv[0]) begin
        for (int i = 0; i < NPP; i++) pp_q[i] <= pp_d[i];
      end
    end
    always_comb for (int i = 0; i < NPP; i++) tree_in[i] = pp_q[i];
  end else begin : g_pp_comb
    always_comb for (int i = 0; i < NPP; i++) tree_in[i] = pp_d[i];
  end

  // 3:2 compressor levels until two rows remain; leftover rows pass to the next level.
  logic [PW-1:0] tr [NPP];
  logic [PW-1:0] nx [NPP];
  logic [PW-1:0] sum_d, car_d;
  int            n, nn, full;

  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      tr[i] = tree_in[i];
      nx[i] = '0;
    end
    n    = NPP;
    nn   = 0;
    full = 0;
    for (int lvl = 0; lvl < NPP; lvl++) begin
      if (n > 2) begin
        nn   = 0;
        full = (n / 3) * 3;
        for (int i = 0; i < NPP; i++) nx[i] = '0;
        for (int g = 0; g < NPP; g++) begin
          if (3*g + 2 < n) begin
            nx[nn]   = tr[3*g] ^ tr[3*g+1] ^ tr[3*g+2];
            nx[nn+1] = ((tr[3*g] & tr[3*g+1]) | (tr[3*g] & tr[3*g+2]) |
                        (tr[3*g+1] & tr[3*g+2])) << 1;
            nn = nn + 2;
          end
        end
        for (int r = 0; r < NPP; r++) begin
          if (r >= full && r < n) begin
            nx[nn] = tr[r];
            nn = nn + 1;
          end
        end
        for (int i = 0; i < NPP; i++) tr[i] = nx[i];
        n = nn;
      end
    end
    sum_d = tr[0];
    car_d = tr[1];
  end

  logic [PW-1:0] cpa_s, cpa_c, prod_d, prod_q;

  if (STAGES >= 2) begin : g_tree_reg
    logic [PW-1:0] sum_q, car_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
        car_q <= '0;
      end else if (adv[STAGES-2]) begin
        sum_q <= sum_d;
        car_q <= car_d;
      end
    end
    assign cpa_s = sum_q;
    assign cpa_c = car_q;
  end else begin : g_tree_comb
    assign cpa_s = sum_d;
    assign cpa_c = car_d;
  end

  assign prod_d = cpa_s + cpa_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  prod_q <= '0;
    else if (adv[STAGES-1])   prod_q <= prod_d;
  end

  // A stage may move when any stage from it to the output has a hole, or the output drains.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = io.out_ready;
      for (int j = k; j < STAGES; j++) adv[k] = adv[k] | ~v_q[j];
    end
  end

  assign io.in_ready = (~v_q[0] | adv[0]) & ~flush;
  assign in_fire     = io.in_valid & io.in_ready;

  always_comb begin
    v_d    = v_q;
    v_d[0] = adv[0] ? in_fire : v_q[0];
    for (int k = 1; k < STAGES; k++) v_d[k] = adv[k] ? v_q[k-1] : v_q[k];
    if (flush) v_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        op_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      if (adv[0]) begin
        op_q[0]  <= io.in_op;
        tag_q[0] <= io.in_tag;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          op_q[k]  <= op_q[k-1];
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

  assign io.out_valid = v_q[STAGES-1];
  assign io.out_prod  = prod_q;
  assign io.out_tag   = tag_q[STAGES-1];
  assign io.out_res   = (op_q[STAGES-1] == 2'd0) ? prod_q[WIDTH-1:0] : prod_q[PW-1:WIDTH];
endmodule

// File: tb/tb_booth_mul_pipe.sv
// Directed and swept checks of booth_mul_pipe at 32/3, 8/1 and 16/2 (WIDTH/STAGES).
module tb_booth_mul_pipe;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  booth_mul_if #(.WIDTH(32), .TAG_W(5)) m   ();
  booth_mul_if #(.WIDTH(8),  .TAG_W(5)) m8  ();
  booth_mul_if #(.WIDTH(16), .TAG_W(5)) m16 ();

  booth_mul_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .io(m.slave));
  booth_mul_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(5)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .io(m8.slave));
  booth_mul_pipe #(.WIDTH(16), .STAGES(2), .TAG_W(5)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .io(m16.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input int w, input logic [1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [127:0] ax, bx, p;
    logic [63:0] mask;
    ax = {96'd0, a};
    bx = {96'd0, b};
    if (op != 2'd3 && a[w-1]) ax = ax - (128'sd1 <<< w);
    if (op[1] == 1'b0 && b[w-1]) bx = bx - (128'sd1 <<< w);
    p = ax * bx;
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
    return p[63:0] & mask;
  endfunction

  // Issues one op on the 32-bit port and waits (bounded) for its result.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [63:0] prod,
                       output logic [31:0] res, output logic [4:0] otag, output int lat);
    m.in_valid = 1'b1; m.in_op = op; m.in_a = a; m.in_b = b; m.in_tag = tag;
    m.out_ready = 1'b1;
    tick;
    m.in_valid = 1'b0;
    lat = 1;
    while (!m.out_valid && lat < 20) begin
      tick;
      lat++;
    end
    prod = m.out_prod; res = m.out_res; otag = m.out_tag;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0;
    m.in_valid = 0;   m.in_op = 0;   m.in_a = 0;   m.in_b = 0;   m.in_tag = 0;   m.out_ready = 1;
    m8.in_valid = 0;  m8.in_op = 0;  m8.in_a = 0;  m8.in_b = 0;  m8.in_tag = 0;  m8.out_ready = 1;
    m16.in_valid = 0; m16.in_op = 0; m16.in_a = 0; m16.in_b = 0; m16.in_tag = 0; m16.out_ready = 1;
    tick; tick;
    n_cmp++; if (m.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", m.out_valid); end
    n_cmp++; if (m.out_prod !== 64'd0) begin n_bad++; $display("FAIL rst_out_prod: got %h want 0", m.out_prod); end
    n_cmp++; if (m.out_res !== 32'd0) begin n_bad++; $display("FAIL rst_out_res: got %h want 0", m.out_res); end
    n_cmp++; if (m.out_tag !== 5'd0) begin n_bad++; $display("FAIL rst_out_tag: got %h want 0", m.out_tag); end
    n_cmp++; if (m.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", m.in_ready); end
    n_cmp++; if (m8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_w8_valid: got %b want 0", m8.out_valid); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_modes;
    logic [1:0]  ops [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    logic [31:0] av  [8] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h80000000};
    logic [31:0] bv  [8] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h00000007, 32'h80000000, 32'h00000003};
    logic [63:0] ep  [8] = '{64'h3FFFFFFF_00000001, 64'h40000000_00000000,
                             64'h00000000_00000001, 64'hFFFFFFFF_00000001,
                             64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB,
                             64'hC0000000_00000000, 64'h00000001_80000000};
    logic [31:0] er  [8] = '{32'h00000001, 32'h40000000, 32'h00000000, 32'hFFFFFFFF,
                             32'hFFFFFFFE, 32'hFFFFFFEB, 32'hC0000000, 32'h00000001};
    logic [63:0] prod;
    logic [31:0] res;
    logic [4:0]  otag;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      run32(ops[i], av[i], bv[i], 5'(i), prod, res, otag, lat);
      n_cmp++; if (prod !== ep[i]) begin n_bad++; $display("FAIL mode_prod[%0d]: got %h want %h", i, prod, ep[i]); end
      n_cmp++; if (res !== er[i]) begin n_bad++; $display("FAIL mode_res[%0d]: got %h want %h", i, res, er[i]); end
      n_cmp++; if (otag !== 5'(i)) begin n_bad++; $display("FAIL mode_tag[%0d]: got %0d want %0d", i, otag, i); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mode_latency[%0d]: got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_back_to_back;
    m.out_ready = 1'b1;
    for (int s = 0; s < 13; s++) begin
      n_cmp++;
      if (m.out_valid !== 1'((s >= 3) && (s <= 10))) begin
        n_bad++; $display("FAIL b2b_valid[step %0d]: got %b want %b", s, m.out_valid, (s >= 3) && (s <= 10));
      end
      if (s >= 3 && s <= 10) begin
        n_cmp++; if (m.out_tag !== 5'(s-3)) begin n_bad++; $display("FAIL b2b_tag[step %0d]: got %0d want %0d", s, m.out_tag, s-3); end
        n_cmp++; if (m.out_res !== 32'((s-2)*s)) begin n_bad++; $display("FAIL b2b_res[step %0d]: got %0d want %0d", s, m.out_res, (s-2)*s); end
      end
      if (s < 8) begin
        m.in_valid = 1'b1; m.in_op = 2'd0; m.in_a = 32'(s+1); m.in_b = 32'(s+3); m.in_tag = 5'(s);
        #1;
        n_cmp++; if (m.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[step %0d]: got %b want 1", s, m.in_ready); end
      end else begin
        m.in_valid = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    int k = 0;
    int got = 0;
    m.out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      m.in_valid = 1'b1; m.in_op = 2'd0; m.in_a = 32'(k+2); m.in_b = 32'd5; m.in_tag = 5'(10+k);
      #1;
      n_cmp++; if (m.in_ready !== 1'(s < 3)) begin n_bad++; $display("FAIL bp_fill_ready[step %0d]: got %b want %b", s, m.in_ready, s < 3); end
      if (m.in_ready) k++;
      tick;
    end
    for (int s = 0; s < 4; s++) begin
      n_cmp++; if (m.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", s, m.in_ready); end
      n_cmp++; if (m.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", s, m.out_valid); end
      n_cmp++; if (m.out_tag !== 5'd10) begin n_bad++; $display("FAIL bp_hold_tag[%0d]: got %0d want 10", s, m.out_tag); end
      n_cmp++; if (m.out_res !== 32'd10) begin n_bad++; $display("FAIL bp_hold_res[%0d]: got %0d want 10", s, m.out_res); end
      tick;
    end
    m.out_ready = 1'b1;
    for (int s = 0; s < 20 && got < 5; s++) begin
      m.in_valid = 1'(k < 5); m.in_a = 32'(k+2); m.in_tag = 5'(10+k);
      #1;
      if (m.out_valid) begin
        n_cmp++; if (m.out_tag !== 5'(10+got)) begin n_bad++; $display("FAIL bp_drain_tag[%0d]: got %0d want %0d", got, m.out_tag, 10+got); end
        n_cmp++; if (m.out_res !== 32'((got+2)*5)) begin n_bad++; $display("FAIL bp_drain_res[%0d]: got %0d want %0d", got, m.out_res, (got+2)*5); end
        got++;
      end
      if (m.in_valid && m.in_ready) k++;
      tick;
    end
    m.in_valid = 1'b0;
    n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 5", got); end
    n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL bp_accept_count: got %0d want 5", k); end
    n_cmp++; if (m.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_duplicate: got valid %b want 0", m.out_valid); end
  endtask

  task automatic test_flush;
    logic [63:0] prod;
    logic [31:0] res;
    logic [4:0]  otag;
    int          lat;
    m.out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      m.in_valid = 1'b1; m.in_op = 2'd0; m.in_a = 32'd3; m.in_b = 32'd3; m.in_tag = 5'(20+s);
      tick;
    end
    m.in_tag = 5'd22; flush = 1'b1;
    #1;
    n_cmp++; if (m.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", m.in_ready); end
    tick;
    flush = 1'b0; m.in_valid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      n_cmp++; if (m.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_killed_valid[%0d]: got %b want 0", s, m.out_valid); end
      tick;
    end
    run32(2'd0, 32'd6, 32'd7, 5'd23, prod, res, otag, lat);
    n_cmp++; if (res !== 32'd42) begin n_bad++; $display("FAIL flush_next_res: got %0d want 42", res); end
    n_cmp++; if (otag !== 5'd23) begin n_bad++; $display("FAIL flush_next_tag: got %0d want 23", otag); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL flush_next_latency: got %0d want 3", lat); end
  endtask

  task automatic test_rst_midstream;
    logic [63:0] prod;
    logic [31:0] res;
    logic [4:0]  otag;
    int          lat;
    m.out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      m.in_valid = 1'b1; m.in_op = 2'd0; m.in_a = 32'd9; m.in_b = 32'd9; m.in_tag = 5'(24+s);
      tick;
    end
    m.in_valid = 1'b0;
    tick;
    n_cmp++; if (m.out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre_valid: got %b want 1", m.out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (m.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_async_valid: got %b want 0", m.out_valid); end
    tick;
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      n_cmp++; if (m.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_killed_valid[%0d]: got %b want 0", s, m.out_valid); end
      tick;
    end
    run32(2'd3, 32'hFFFFFFFF, 32'd2, 5'd26, prod, res, otag, lat);
    n_cmp++; if (prod !== 64'h00000001_FFFFFFFE) begin n_bad++; $display("FAIL rst_mid_next_prod: got %h want 00000001fffffffe", prod); end
    n_cmp++; if (res !== 32'd1) begin n_bad++; $display("FAIL rst_mid_next_res: got %h want 1", res); end
    n_cmp++; if (otag !== 5'd26) begin n_bad++; $display("FAIL rst_mid_next_tag: got %0d want 26", otag); end
  endtask

  task automatic test_sweep_w8;
    logic [1:0]  op;
    logic [7:0]  a, b;
    logic [63:0] ex;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      op = 2'(i % 4);
      a  = (i < 4) ? 8'h80 : (i < 8) ? 8'hFF : 8'($urandom);
      b  = (i < 4) ? 8'h80 : (i < 8) ? 8'hFF : 8'($urandom);
      m8.in_valid = 1'b1; m8.in_op = op; m8.in_a = a; m8.in_b = b; m8.in_tag = 5'(i);
      tick;
      m8.in_valid = 1'b0;
      lat = 1;
      while (!m8.out_valid && lat < 10) begin tick; lat++; end
      ex = ref_prod(8, op, {24'd0, a}, {24'd0, b});
      n_cmp++; if (m8.out_prod !== ex[15:0]) begin n_bad++; $display("FAIL w8_prod[%0d] op%0d %h*%h: got %h want %h", i, op, a, b, m8.out_prod, ex[15:0]); end
      n_cmp++; if (m8.out_res !== ((op == 2'd0) ? ex[7:0] : ex[15:8])) begin n_bad++; $display("FAIL w8_res[%0d]: got %h prod %h", i, m8.out_res, ex[15:0]); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL w8_latency[%0d]: got %0d want 1", i, lat); end
      tick;
    end
  endtask

  task automatic test_sweep_w16;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [63:0] ex;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      op = 2'(i % 4);
      a  = (i < 4) ? 16'h8000 : (i < 8) ? 16'hFFFF : 16'($urandom);
      b  = (i < 4) ? 16'h7FFF : (i < 8) ? 16'h8000 : 16'($urandom);
      m16.in_valid = 1'b1; m16.in_op = op; m16.in_a = a; m16.in_b = b; m16.in_tag = 5'(i);
      tick;
      m16.in_valid = 1'b0;
      lat = 1;
      while (!m16.out_valid && lat < 10) begin tick; lat++; end
      ex = ref_prod(16, op, {16'd0, a}, {16'd0, b});
      n_cmp++; if (m16.out_prod !== ex[31:0]) begin n_bad++; $display("FAIL w16_prod[%0d] op%0d %h*%h: got %h want %h", i, op, a, b, m16.out_prod, ex[31:0]); end
      n_cmp++; if (m16.out_res !== ((op == 2'd0) ? ex[15:0] : ex[31:16])) begin n_bad++; $display("FAIL w16_res[%0d]: got %h prod %h", i, m16.out_res, ex[31:0]); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL w16_latency[%0d]: got %0d want 2", i, lat); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_modes;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_rst_midstream;
    test_sweep_w8;
    test_sweep_w16;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
